// File: rtl/pipeline_delay_pkg.sv
// pipeline_delay_pkg: shared parameter legality check for the response-path delay line
package pipeline_delay_pkg;
  function automatic bit pd_params_ok(int w, int d);
    return (w >= 1) && (d >= 0);
  endfunction
endpackage

// File: rtl/pipeline_delay_stage.sv
// pipeline_delay_stage: one WIDTH-bit async-reset register loading RESET_VALUE while reset_n is low
module pipeline_delay_stage #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_q <= RESET_VALUE;
    else r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/pipeline_delay.sv
// pipeline_delay: fixed-latency bus retimer, out(t) = in(t-DEPTH); DEPTH=0 is a plain wire
module pipeline_delay
  import pipeline_delay_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  if (!pd_params_ok(WIDTH, DEPTH)) begin : g_bad_params
    $fatal(1, "pipeline_delay: WIDTH must be >= 1 and DEPTH >= 0");
  end
  if (DEPTH == 0) begin : g_wire
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clock ^ reset_n;
    assign out = in;
  end else begin : g_pipe
    // w_stage[0] is the input; w_stage[s+1] is the output of register stage s
    logic [WIDTH-1:0] w_stage [DEPTH+1];
    assign w_stage[0] = in;
    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      pipeline_delay_stage #(
        .WIDTH(WIDTH),
        .RESET_VALUE(RESET_VALUE)
      ) u_stage (
        .clock(clock),
        .reset_n(reset_n),
        .i_d(w_stage[s]),
        .o_q(w_stage[s+1])
      );
    end
    assign out = w_stage[DEPTH];
  end
endmodule

// File: tb/tb_pipeline_delay.sv
// tb_pipeline_delay: directed checks of reset, latency, streaming, alignment and DEPTH=0 behaviour
module tb_pipeline_delay;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        in1;
  logic [63:0] in64;
  logic [7:0]  in8, z8, h8;
  logic        out1, ack3;
  logic [63:0] out64, data3;
  logic [7:0]  out8, outz, outh;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  pipeline_delay #(1) u_w1d1 (.clock(clock), .reset_n(reset_n), .in(in1), .out(out1));
  pipeline_delay #(64, 1) u_w64d1 (.clock(clock), .reset_n(reset_n), .in(in64), .out(out64));
  pipeline_delay #(8, 3) u_w8d3 (.clock(clock), .reset_n(reset_n), .in(in8), .out(out8));
  pipeline_delay #(1, 3) u_ack (.clock(clock), .reset_n(reset_n), .in(in1), .out(ack3));
  pipeline_delay #(64, 3) u_data (.clock(clock), .reset_n(reset_n), .in(in64), .out(data3));
  pipeline_delay #(8, 0) u_wire (.clock(clock), .reset_n(reset_n), .in(z8), .out(outz));
  pipeline_delay #(.WIDTH(8), .DEPTH(2), .RESET_VALUE(8'hA5)) u_a5 (.clock(clock), .reset_n(reset_n), .in(h8), .out(outh));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [63:0] v64;
    reset_n = 1'b0;
    in1 = 1'b0; in64 = '0; in8 = '0; z8 = '0; h8 = '0;
    repeat (2) step();
    chk("rst_out1", 64'(out1), 64'h0);
    chk("rst_out64", out64, 64'h0);
    chk("rst_out8", 64'(out8), 64'h0);
    chk("rst_a5", 64'(outh), 64'hA5);
    reset_n = 1'b1;
    // async reset: assert between edges and observe without a clock
    in1 = 1'b1;
    step();
    chk("w1_capture", 64'(out1), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("w1_async_rst", 64'(out1), 64'h0);
    chk("a5_async_rst", 64'(outh), 64'hA5);
    reset_n = 1'b1;
    in1 = 1'b0;
    step();
    chk("w1_after_rel", 64'(out1), 64'h0);
    v64 = 64'h0000000100010010;
    in64 = v64;
    step();
    in64 = '0;
    chk("lat_w64_d1", out64, v64);
    step();
    chk("lat_w64_back0", out64, 64'h0);
    for (int k = 1; k <= 7; k++) begin
      in8 = (k <= 4) ? 8'(k) : 8'h00;
      step();
      chk($sformatf("stream_k%0d", k), 64'(out8), (k >= 3 && k <= 6) ? 64'(k - 2) : 64'h0);
    end
    for (int k = 1; k <= 2; k++) begin
      in8 = 8'h10 + 8'(k);
      step();
    end
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_async", 64'(out8), 64'h0);
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in8 = 8'h20 + 8'(k);
      step();
      chk($sformatf("mid_rst_k%0d", k), 64'(out8), (k >= 3) ? 64'(8'h20 + 8'(k - 2)) : 64'h0);
    end
    in8 = '0;
    v64 = 64'hDEADBEEF01234567;
    for (int k = 1; k <= 4; k++) begin
      in1 = (k == 1);
      in64 = (k == 1) ? v64 : 64'h0;
      step();
      chk($sformatf("align_ack_k%0d", k), 64'(ack3), (k == 3) ? 64'h1 : 64'h0);
      chk($sformatf("align_data_k%0d", k), data3, (k == 3) ? v64 : 64'h0);
    end
    z8 = 8'h5A;
    #1;
    chk("d0_5a", 64'(outz), 64'h5A);
    z8 = 8'hC3;
    #1;
    chk("d0_c3", 64'(outz), 64'hC3);
    h8 = 8'h77;
    reset_n = 1'b0;
    z8 = 8'h3C;
    #1;
    chk("d0_in_reset", 64'(outz), 64'h3C);
    step();
    chk("a5_held", 64'(outh), 64'hA5);
    reset_n = 1'b1;
    step();
    chk("a5_rel_k1", 64'(outh), 64'hA5);
    step();
    chk("a5_rel_k2", 64'(outh), 64'h77);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
